// File: rtl/m_phy_lane_sync_ctrl.sv
// Lane synchroniser for an M-PHY style deserializer: comma hunting, sync confirmation and loss tracking.
// Optional sync-loss statistics counter is built only when M_PHY_SYNC_STATS_EN is defined.
module m_phy_lane_sync_ctrl #(
    parameter logic [9:0]  COMMA_DEFAULT = 10'h0FA,
    parameter int unsigned CONFIRM_CNT   = 4,
    parameter int unsigned LOSS_THRESH   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync_en,
    input  logic [9:0]  comma_cfg,
    input  logic [7:0]  comma_period,
    input  logic [9:0]  s2p_data,
    input  logic        s2p_valid,
    input  logic        s2p_align,
    output logic [9:0]  comma_char,
    output logic        unlock,
    output logic        lane_sync,
    output logic [9:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_is_comma,
    output logic [3:0]  err_cnt,
    output logic [15:0] loss_cnt
);

    localparam int unsigned PERIOD_W = 8;
    localparam int unsigned GOOD_W   = 8;
    localparam int unsigned ERR_W    = 4;

    typedef enum logic [2:0] {
        DISABLED,
        WAIT_ALIGN,
        CONFIRM,
        SYNC,
        RELOCK
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] period_cnt;
    logic [GOOD_W-1:0]   good_cnt;

    logic             is_comma_c;
    logic             at_slot_c;
    logic             good_c;
    logic             bad_c;
    logic [ERR_W-1:0] err_inc_c;

    // Symbol classification against the expected comma slot
    always_comb begin
        is_comma_c = (s2p_data == comma_char);
        at_slot_c  = (comma_period != 8'd0) && (period_cnt == (comma_period - 8'd1));
        good_c     = s2p_valid && is_comma_c && (at_slot_c || (comma_period == 8'd0));
        bad_c      = s2p_valid && (comma_period != 8'd0) && (is_comma_c != at_slot_c);
        err_inc_c  = (err_cnt == 4'hF) ? err_cnt : (err_cnt + 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DISABLED;
            comma_char  <= COMMA_DEFAULT;
            unlock      <= 1'b0;
            lane_sync   <= 1'b0;
            rx_data     <= 10'd0;
            rx_valid    <= 1'b0;
            rx_is_comma <= 1'b0;
            err_cnt     <= 4'd0;
            period_cnt  <= 8'd0;
            good_cnt    <= 8'd0;
`ifdef M_PHY_SYNC_STATS_EN
            loss_cnt    <= 16'd0;
`endif
        end else begin
            unlock      <= 1'b0;
            lane_sync   <= 1'b0;
            rx_valid    <= s2p_valid && (state == SYNC);
            rx_is_comma <= is_comma_c;
            if (state == SYNC) begin
                rx_data <= s2p_data;
            end

            if (state == DISABLED) begin
                comma_char <= comma_cfg;
            end

            // Period counter only runs while hunting or locked; a comma or a slot error restarts it
            if ((state == CONFIRM) || (state == SYNC)) begin
                if (s2p_valid) begin
                    period_cnt <= (is_comma_c || bad_c) ? 8'd0 : (period_cnt + 8'd1);
                end
            end else begin
                period_cnt <= 8'd0;
            end

            if (!sync_en) begin
                state <= DISABLED;
            end else begin
                case (state)
                    DISABLED: begin
                        state    <= WAIT_ALIGN;
                        good_cnt <= 8'd0;
                        err_cnt  <= 4'd0;
                    end
                    WAIT_ALIGN: begin
                        if (s2p_align) begin
                            state    <= CONFIRM;
                            good_cnt <= 8'd0;
                        end
                    end
                    CONFIRM: begin
                        if (!s2p_align) begin
                            state <= WAIT_ALIGN;
                        end else if (bad_c) begin
                            state  <= RELOCK;
                            unlock <= 1'b1;
                        end else if (good_c) begin
                            good_cnt <= good_cnt + 8'd1;
                            if ((good_cnt + 8'd1) == GOOD_W'(CONFIRM_CNT)) begin
                                state     <= SYNC;
                                lane_sync <= 1'b1;
                            end
                        end
                    end
                    SYNC: begin
                        if (!s2p_align) begin
                            state <= WAIT_ALIGN;
`ifdef M_PHY_SYNC_STATS_EN
                            if (loss_cnt != 16'hFFFF) loss_cnt <= loss_cnt + 16'd1;
`endif
                        end else begin
                            lane_sync <= 1'b1;
                            if (bad_c) begin
                                err_cnt <= err_inc_c;
                                if (err_inc_c >= ERR_W'(LOSS_THRESH)) begin
                                    state     <= RELOCK;
                                    unlock    <= 1'b1;
                                    lane_sync <= 1'b0;
`ifdef M_PHY_SYNC_STATS_EN
                                    if (loss_cnt != 16'hFFFF) loss_cnt <= loss_cnt + 16'd1;
`endif
                                end
                            end else if (good_c && (err_cnt != 4'd0)) begin
                                err_cnt <= err_cnt - 4'd1;
                            end
                        end
                    end
                    RELOCK: begin
                        state   <= WAIT_ALIGN;
                        err_cnt <= 4'd0;
                    end
                    default: state <= DISABLED;
                endcase
            end
        end
    end

`ifndef M_PHY_SYNC_STATS_EN
    assign loss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_m_phy_lane_sync_ctrl.sv
// Scenario bench for m_phy_lane_sync_ctrl; forwarded symbols are checked through an expected-value queue.
module tb_m_phy_lane_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync_en;
    logic [9:0]  comma_cfg;
    logic [7:0]  comma_period;
    logic [9:0]  s2p_data;
    logic        s2p_valid;
    logic        s2p_align;
    logic [9:0]  comma_char;
    logic        unlock;
    logic        lane_sync;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic        rx_is_comma;
    logic [3:0]  err_cnt;
    logic [15:0] loss_cnt;

`ifdef M_PHY_SYNC_STATS_EN
    localparam logic [15:0] LOSS1 = 16'd1;
`else
    localparam logic [15:0] LOSS1 = 16'd0;
`endif

    m_phy_lane_sync_ctrl dut (
        .clk(clk), .reset(reset), .sync_en(sync_en), .comma_cfg(comma_cfg),
        .comma_period(comma_period), .s2p_data(s2p_data), .s2p_valid(s2p_valid),
        .s2p_align(s2p_align), .comma_char(comma_char), .unlock(unlock),
        .lane_sync(lane_sync), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_is_comma(rx_is_comma), .err_cnt(err_cnt), .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          exp_sync;
    logic [9:0]  cur_comma;
    logic [10:0] exp_q[$];
    logic [10:0] obs_mem [0:1023];
    int          obs_wr = 0;

    // Capture every forwarded symbol as {is_comma, data}
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && obs_wr < 1024) begin
            obs_mem[obs_wr] <= {rx_is_comma, rx_data};
            obs_wr          <= obs_wr + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end want end");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [9:0] d, input logic v);
        s2p_data  = d;
        s2p_valid = v;
        if (v && exp_sync) exp_q.push_back({(d == cur_comma), d});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) send(10'h000, 1'b0);
    endtask

    task automatic group(input logic [9:0] c);
        for (int i = 0; i < 3; i++) send(10'h150 + 10'(i), 1'b1);
        send(c, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1; sync_en = 1'b0; s2p_align = 1'b0; s2p_valid = 1'b0;
        s2p_data = 10'h000; comma_cfg = 10'h0FA; comma_period = 8'd4;
        cur_comma = 10'h0FA; exp_sync = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic sync_up();
        do_reset();
        sync_en = 1'b1; s2p_align = 1'b1;
        idle(2);
        repeat (4) group(cur_comma);
        exp_sync = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sync_en = 1'b0; s2p_align = 1'b0; s2p_valid = 1'b0;
        s2p_data = 10'h000; comma_cfg = 10'h1AB; comma_period = 8'd4;
        cur_comma = 10'h0FA; exp_sync = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (comma_char !== 10'h0FA) begin n_fail++; $display("FAIL reset_comma_char: got %h want 0fa", comma_char); end
        n_checks++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL reset_unlock: got %b want 0", unlock); end
        n_checks++; if (lane_sync !== 1'b0) begin n_fail++; $display("FAIL reset_lane_sync: got %b want 0", lane_sync); end
        n_checks++; if (rx_data !== 10'h000) begin n_fail++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (rx_is_comma !== 1'b0) begin n_fail++; $display("FAIL reset_rx_is_comma: got %b want 0", rx_is_comma); end
        n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        n_checks++; if (loss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (comma_char !== 10'h1AB) begin n_fail++; $display("FAIL disabled_loads_cfg: got %h want 1ab", comma_char); end
    endtask

    task automatic test_sync();
        do_reset();
        sync_en = 1'b1; s2p_align = 1'b1;
        idle(2);
        for (int g = 0; g < 4; g++) begin
            group(cur_comma);
            n_checks++; if (lane_sync !== (g == 3)) begin n_fail++; $display("FAIL sync_lane_sync_%0d: got %b want %b", g, lane_sync, (g == 3)); end
        end
        exp_sync = 1'b1;
        send(10'h155, 1'b1);
        n_checks++; if (rx_valid !== 1'b1 || rx_data !== 10'h155) begin n_fail++; $display("FAIL sync_rx_latency: got %b/%h want 1/155", rx_valid, rx_data); end
        idle(1);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL sync_rx_gap: got %b want 0", rx_valid); end
        send(10'h156, 1'b1); send(10'h157, 1'b1); send(cur_comma, 1'b1);
        n_checks++; if (rx_is_comma !== 1'b1) begin n_fail++; $display("FAIL sync_rx_is_comma: got %b want 1", rx_is_comma); end
        n_checks++; if (lane_sync !== 1'b1 || err_cnt !== 4'd0) begin n_fail++; $display("FAIL sync_hold: got %b/%0d want 1/0", lane_sync, err_cnt); end
        group(cur_comma);
        n_checks++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL sync_no_unlock: got %b want 0", unlock); end
    endtask

    task automatic test_err_relock();
        sync_up();
        for (int k = 1; k <= 3; k++) begin
            send(cur_comma, 1'b1);
            n_checks++; if (err_cnt !== 4'(k)) begin n_fail++; $display("FAIL relock_err_cnt_%0d: got %0d want %0d", k, err_cnt, k); end
            n_checks++; if (unlock !== (k == 3)) begin n_fail++; $display("FAIL relock_unlock_%0d: got %b want %b", k, unlock, (k == 3)); end
            n_checks++; if (lane_sync !== (k < 3)) begin n_fail++; $display("FAIL relock_lane_sync_%0d: got %b want %b", k, lane_sync, (k < 3)); end
        end
        exp_sync = 1'b0;
        idle(1);
        n_checks++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL relock_single_pulse: got %b want 0", unlock); end
        n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL relock_err_clear: got %0d want 0", err_cnt); end
        n_checks++; if (loss_cnt !== LOSS1) begin n_fail++; $display("FAIL relock_loss_cnt: got %0d want %0d", loss_cnt, LOSS1); end
        idle(1);
        for (int g = 0; g < 4; g++) begin
            group(cur_comma);
            n_checks++; if (lane_sync !== (g == 3)) begin n_fail++; $display("FAIL relock_resync_%0d: got %b want %b", g, lane_sync, (g == 3)); end
        end
    endtask

    task automatic test_confirm_fail();
        do_reset();
        sync_en = 1'b1; s2p_align = 1'b1;
        idle(2);
        repeat (2) group(cur_comma);
        for (int i = 0; i < 4; i++) begin
            send(10'h150 + 10'(i), 1'b1);
            n_checks++; if (unlock !== (i == 3)) begin n_fail++; $display("FAIL confirm_unlock_%0d: got %b want %b", i, unlock, (i == 3)); end
            n_checks++; if (lane_sync !== 1'b0) begin n_fail++; $display("FAIL confirm_lane_sync_%0d: got %b want 0", i, lane_sync); end
        end
        idle(1);
        n_checks++; if (unlock !== 1'b0 || lane_sync !== 1'b0) begin n_fail++; $display("FAIL confirm_after_relock: got %b/%b want 0/0", unlock, lane_sync); end
    endtask

    task automatic test_comma_cfg();
        sync_up();
        comma_cfg = 10'h305;
        group(cur_comma);
        n_checks++; if (comma_char !== 10'h0FA) begin n_fail++; $display("FAIL cfg_held_in_sync: got %h want 0fa", comma_char); end
        n_checks++; if (lane_sync !== 1'b1) begin n_fail++; $display("FAIL cfg_still_sync: got %b want 1", lane_sync); end
        sync_en = 1'b0; exp_sync = 1'b0;
        idle(1);
        n_checks++; if (lane_sync !== 1'b0 || unlock !== 1'b0) begin n_fail++; $display("FAIL cfg_disable: got %b/%b want 0/0", lane_sync, unlock); end
        idle(1);
        n_checks++; if (comma_char !== 10'h305) begin n_fail++; $display("FAIL cfg_loaded: got %h want 305", comma_char); end
        sync_en = 1'b1;
        idle(1);
        cur_comma = 10'h305;
        idle(1);
        repeat (4) group(cur_comma);
        n_checks++; if (lane_sync !== 1'b1 || comma_char !== 10'h305) begin n_fail++; $display("FAIL cfg_new_comma_sync: got %b/%h want 1/305", lane_sync, comma_char); end
    endtask

    task automatic test_disable_at_thresh();
        sync_up();
        send(cur_comma, 1'b1); send(cur_comma, 1'b1);
        n_checks++; if (err_cnt !== 4'd2) begin n_fail++; $display("FAIL dis_err_cnt: got %0d want 2", err_cnt); end
        sync_en = 1'b0;
        send(cur_comma, 1'b1);
        exp_sync = 1'b0;
        n_checks++; if (unlock !== 1'b0 || lane_sync !== 1'b0) begin n_fail++; $display("FAIL dis_at_thresh: got %b/%b want 0/0", unlock, lane_sync); end
        idle(1);
        n_checks++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL dis_no_late_unlock: got %b want 0", unlock); end
    endtask

    task automatic test_align_loss();
        sync_up();
        s2p_align = 1'b0; exp_sync = 1'b0;
        idle(1);
        n_checks++; if (lane_sync !== 1'b0 || unlock !== 1'b0) begin n_fail++; $display("FAIL align_loss: got %b/%b want 0/0", lane_sync, unlock); end
        n_checks++; if (loss_cnt !== LOSS1) begin n_fail++; $display("FAIL align_loss_cnt: got %0d want %0d", loss_cnt, LOSS1); end
        idle(1);
        n_checks++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL align_loss_unlock: got %b want 0", unlock); end
    endtask

    task automatic test_reset_midop();
        sync_up();
        send(cur_comma, 1'b1); send(cur_comma, 1'b1);
        exp_sync = 1'b0; reset = 1'b1;
        send(cur_comma, 1'b1);
        n_checks++; if (err_cnt !== 4'd0 || unlock !== 1'b0) begin n_fail++; $display("FAIL midreset_err_unlock: got %0d/%b want 0/0", err_cnt, unlock); end
        n_checks++; if (lane_sync !== 1'b0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_sync_valid: got %b/%b want 0/0", lane_sync, rx_valid); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_period_zero();
        do_reset();
        comma_period = 8'd0; sync_en = 1'b1; s2p_align = 1'b1;
        idle(2);
        for (int g = 0; g < 7; g++) begin
            int n;
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) send(10'h100 | 10'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            send(cur_comma, 1'b1);
            if (g < 4) begin
                n_checks++; if (lane_sync !== (g == 3)) begin n_fail++; $display("FAIL p0_lane_sync_%0d: got %b want %b", g, lane_sync, (g == 3)); end
            end
            if (g == 3) exp_sync = 1'b1;
            n_checks++; if (err_cnt !== 4'd0 || unlock !== 1'b0) begin n_fail++; $display("FAIL p0_err_%0d: got %0d/%b want 0/0", g, err_cnt, unlock); end
        end
        exp_sync = 1'b0;
        idle(2);
    endtask

    task automatic test_rx_stream();
        idle(2);
        n_checks++; if (obs_wr !== exp_q.size() || exp_q.size() == 0) begin n_fail++; $display("FAIL rx_count: got %0d want %0d", obs_wr, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_wr; i++) begin
            n_checks++; if (obs_mem[i] !== exp_q[i]) begin n_fail++; $display("FAIL rx_item_%0d: got %h want %h", i, obs_mem[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_err_relock();
        test_confirm_fail();
        test_comma_cfg();
        test_disable_at_thresh();
        test_align_loss();
        test_reset_midop();
        test_period_zero();
        test_rx_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_phy_lane_sync_ctrl.md
M_PHY_LANE_SYNC_CTRL -- requirements
Module: m_phy_lane_sync_ctrl

Interface
REQ-001 SHALL have parameter COMMA_DEFAULT, default 10'h0FA, reset value of comma_char.
REQ-002 SHALL have parameter CONFIRM_CNT, default 4, good commas needed to declare sync.
REQ-003 SHALL have parameter LOSS_THRESH, default 3, err_cnt value that forces relock.
REQ-004 SHALL have ports, one per line, as follows. One clock; reset is synchronous and active-high.
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  sync_en  in  1  enable lane synchronisation
  comma_cfg  in  10  comma symbol to program
  comma_period  in  8  valid symbols between commas; 0 disables period check
  s2p_data  in  10  deserializer parallel symbol
  s2p_valid  in  1  s2p_data strobe
  s2p_align  in  1  deserializer alignment-valid
  comma_char  out  10  comma symbol driven to deserializer
  unlock  out  1  one-cycle relock request to deserializer
  lane_sync  out  1  lane synchronised
  rx_data  out  10  registered symbol, forwarded only in SYNC
  rx_valid  out  1  rx_data strobe
  rx_is_comma  out  1  rx_data equals comma_char
  err_cnt  out  4  current error count
  loss_cnt  out  16  sync-loss event count (see Configuration)

Function
REQ-005 SHALL implement states DISABLED, WAIT_ALIGN, CONFIRM, SYNC, RELOCK.
REQ-006 SHALL move to DISABLED the cycle after sync_en=0 sampled, from any state, overriding every other transition.
REQ-007 SHALL load comma_char from comma_cfg only while in DISABLED; comma_char is held in all other states.
REQ-008 DISABLED: sync_en=1 -> WAIT_ALIGN; clear period counter, good counter, err_cnt.
REQ-009 WAIT_ALIGN: s2p_align=1 -> CONFIRM; clear period and good counters.
REQ-010 Period counter (8 bit) SHALL count s2p_valid symbols since last comma, cleared on each comma symbol.
REQ-011 Good event: valid comma with period counter == comma_period-1, or any valid comma when comma_period=0.
REQ-012 Bad event: valid comma with period counter != comma_period-1, or valid non-comma with period counter == comma_period-1 (comma_period != 0); counter then clears.
REQ-013 CONFIRM: good increments good counter; reaching CONFIRM_CNT -> SYNC; any bad -> RELOCK.
REQ-014 SYNC: lane_sync=1; bad increments err_cnt (saturate 15); good decrements err_cnt (floor 0); err_cnt reaching LOSS_THRESH -> RELOCK.
REQ-015 RELOCK: exactly one cycle, unlock=1, err_cnt cleared, then WAIT_ALIGN.
REQ-016 s2p_align=0 in CONFIRM or SYNC SHALL go to WAIT_ALIGN without asserting unlock.
REQ-017 unlock SHALL be 1 only in RELOCK; lane_sync SHALL be 1 only in SYNC.
REQ-018 rx_data/rx_valid/rx_is_comma SHALL be registered copies of s2p_data/s2p_valid/comma match, 1-cycle latency, rx_valid gated by state==SYNC.

Reset
REQ-019 Reset SHALL force DISABLED, comma_char=COMMA_DEFAULT, unlock=0, lane_sync=0, rx_data=0, rx_valid=0, rx_is_comma=0, err_cnt=0, loss_cnt=0, all counters 0.
REQ-020 Reset mid-operation SHALL take effect on the next edge regardless of state; unlock SHALL NOT pulse because of reset.

Configuration
REQ-021 With M_PHY_SYNC_STATS_EN defined, loss_cnt SHALL increment (saturate 16'hFFFF) on every entry into RELOCK from SYNC and on every SYNC->WAIT_ALIGN exit.
REQ-022 Without M_PHY_SYNC_STATS_EN, loss_cnt SHALL be constant 0 and its counter logic SHALL not exist.

Verification
REQ-023 reset, sync_en=1, s2p_align=1, comma_period=4, comma 10'h0FA every 4th valid symbol -> lane_sync=1 after 4th good comma, rx_valid follows s2p_valid 1 cycle late.
REQ-024 In SYNC, three misplaced commas with no intervening good -> err_cnt 1,2,3, single-cycle unlock, state WAIT_ALIGN, loss_cnt=1 with macro.
REQ-025 In CONFIRM after 2 good commas, one non-comma at expected slot -> RELOCK, unlock pulse, lane_sync never 1.
REQ-026 comma_cfg=10'h305 while SYNC -> comma_char stays 10'h0FA; sync_en=0 then 1 -> comma_char=10'h305.
REQ-027 sync_en=0 in same cycle err_cnt reaches LOSS_THRESH -> DISABLED, no unlock pulse.
REQ-028 comma_period=0, commas at random spacing -> sync after 4 commas, err_cnt stays 0.
